// File: rtl/ex_pkg.sv
// Execute-stage shared definitions: datapath width default, ALUOp and
// {funct7,funct3} encodings, multiplier FSM states and the operand
// forwarding selector used by ex_mem_stage.
package ex_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // ALUOp encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // {funct7,funct3}
  localparam logic [9:0] FN_AND  = 10'b0000000_111;
  localparam logic [9:0] FN_XOR  = 10'b0000000_100;
  localparam logic [9:0] FN_SLL  = 10'b0000000_001;
  localparam logic [9:0] FN_ADD  = 10'b0000000_000;
  localparam logic [9:0] FN_SUB  = 10'b0100000_000;
  localparam logic [9:0] FN_MUL  = 10'b0000001_000;
  localparam logic [9:0] FN_SRAI = 10'b0100000_101;
  localparam logic [2:0] F3_ADDI = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_WB    = 2'd2
  } fwd_src_e;

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  function automatic fwd_src_e fwd_select(
    input logic [4:0] rs,
    input logic       exm_we,
    input logic [4:0] exm_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd
  );
    if (exm_we && (exm_rd != 5'd0) && (exm_rd == rs))
      return FWD_EXMEM;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_IDEX;
  endfunction

endpackage

// File: rtl/ex_mem_stage_mul.sv
// Iterative shift-add multiplier (low XLEN bits of a*b).
// Ports:
//   clk_i, rst_i  clock, synchronous active-low reset
//   start         load a/b, clear partial product, arm MUL_STEPS steps
//   a, b          operands, sampled on start
//   freeze        hold every internal register
//   last_step     1 during the cycle that performs the final step
//   product       partial/final product
module ex_mul_iter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            freeze,
  output logic            last_step,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_STEPS - 1);

  logic [XLEN-1:0]  mcand_q;
  logic [XLEN-1:0]  mplier_q;
  logic [XLEN-1:0]  acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (!freeze) begin
      if (start) begin
        mcand_q  <= a;
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= CNT_INIT;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0])
          acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (cnt_q == '0)
          run_q <= 1'b0;
        else
          cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign last_step = run_q && (cnt_q == '0);
  assign product   = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage + EX/MEM pipeline register.
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   MemStall_i              D-cache stall, freezes the whole block
//   RegWrite_i..MemWrite_i  controls from ID/EX
//   ALUOp_i, ALUSrc_i, ALUfunct_i  ALU decode inputs
//   RS1/RS2data_i, Imm_i    operands; RS1/RS2/RDaddr_i register addresses
//   WBRegWrite_i, WBRDaddr_i, WBdata_i  MEM/WB forwarding source
//   RegWrite_o..MemWrite_o, ALUResult_o, RS2data_o, RDaddr_o  EX/MEM register
//   ExStall_o               combinational, high while a MUL occupies EX
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            MemStall_i,
  input  logic            RegWrite_i,
  input  logic            MemtoReg_i,
  input  logic            MemRead_i,
  input  logic            MemWrite_i,
  input  logic [1:0]      ALUOp_i,
  input  logic            ALUSrc_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  input  logic [XLEN-1:0] Imm_i,
  input  logic [9:0]      ALUfunct_i,
  input  logic [4:0]      RS1addr_i,
  input  logic [4:0]      RS2addr_i,
  input  logic [4:0]      RDaddr_i,
  input  logic            WBRegWrite_i,
  input  logic [4:0]      WBRDaddr_i,
  input  logic [XLEN-1:0] WBdata_i,
  output logic            RegWrite_o,
  output logic            MemtoReg_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic [XLEN-1:0] ALUResult_o,
  output logic [XLEN-1:0] RS2data_o,
  output logic [4:0]      RDaddr_o,
  output logic            ExStall_o
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            is_mul;
  logic            ex_stall;
  logic            mul_start;
  logic            mul_last;
  logic [XLEN-1:0] mul_product;
  ex_state_e       state_q;
  ex_state_e       state_d;

  // Operand forwarding
  always_comb begin
    unique case (fwd_select(RS1addr_i, RegWrite_o, RDaddr_o, WBRegWrite_i, WBRDaddr_i))
      FWD_EXMEM: rs1_fwd = ALUResult_o;
      FWD_WB:    rs1_fwd = WBdata_i;
      default:   rs1_fwd = RS1data_i;
    endcase
    unique case (fwd_select(RS2addr_i, RegWrite_o, RDaddr_o, WBRegWrite_i, WBRDaddr_i))
      FWD_EXMEM: rs2_fwd = ALUResult_o;
      FWD_WB:    rs2_fwd = WBdata_i;
      default:   rs2_fwd = RS2data_i;
    endcase
  end

  assign op_b = ALUSrc_i ? Imm_i : rs2_fwd;

  // ALU; MUL only flags itself here, its result comes from ex_mul_iter
  always_comb begin
    alu_res = '0;
    is_mul  = 1'b0;
    case (ALUOp_i)
      ALUOP_ADD: alu_res = rs1_fwd + op_b;
      ALUOP_SUB: alu_res = rs1_fwd - op_b;
      ALUOP_RTYPE: begin
        case (ALUfunct_i)
          FN_AND:  alu_res = rs1_fwd & op_b;
          FN_XOR:  alu_res = rs1_fwd ^ op_b;
          FN_SLL:  alu_res = rs1_fwd << op_b[4:0];
          FN_ADD:  alu_res = rs1_fwd + op_b;
          FN_SUB:  alu_res = rs1_fwd - op_b;
          FN_MUL:  is_mul  = 1'b1;
          default: alu_res = '0;
        endcase
      end
      default: begin
        if (ALUfunct_i[2:0] == F3_ADDI)
          alu_res = rs1_fwd + op_b;
        else if (ALUfunct_i == FN_SRAI)
          alu_res = $signed(rs1_fwd) >>> op_b[4:0];
      end
    endcase
  end

  // MUL sequencing FSM
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ex_stall  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mul && !MemStall_i) begin
          ex_stall  = 1'b1;
          mul_start = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        ex_stall = 1'b1;
        if (mul_last && !MemStall_i)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!MemStall_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Forced low while reset is asserted so upstream stages are not held
  assign ExStall_o = rst_i & ex_stall;

  ex_mul_iter #(
    .XLEN      (XLEN),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (mul_start),
    .a         (rs1_fwd),
    .b         (rs2_fwd),
    .freeze    (MemStall_i),
    .last_step (mul_last),
    .product   (mul_product)
  );

  // EX/MEM register. During a MUL stall only the controls are squashed;
  // the data fields keep loading and are don't-care for the bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      MemRead_o   <= 1'b0;
      MemWrite_o  <= 1'b0;
      ALUResult_o <= '0;
      RS2data_o   <= '0;
      RDaddr_o    <= '0;
    end else if (!MemStall_i) begin
      if (ex_stall) begin
        RegWrite_o <= 1'b0;
        MemtoReg_o <= 1'b0;
        MemRead_o  <= 1'b0;
        MemWrite_o <= 1'b0;
      end else begin
        RegWrite_o <= RegWrite_i;
        MemtoReg_o <= MemtoReg_i;
        MemRead_o  <= MemRead_i;
        MemWrite_o <= MemWrite_i;
      end
      ALUResult_o <= (state_q == ST_DONE) ? mul_product : alu_res;
      RS2data_o   <= rs2_fwd;
      RDaddr_o    <= RDaddr_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemStall_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [1:0]  ALUOp_i;
  logic        ALUSrc_i;
  logic [31:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0]  ALUfunct_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic        WBRegWrite_i;
  logic [4:0]  WBRDaddr_i;
  logic [31:0] WBdata_i;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic [31:0] ALUResult_o, RS2data_o;
  logic [4:0]  RDaddr_o;
  logic        ExStall_o;

  ex_mem_stage #(
    .XLEN      (32),
    .MUL_STEPS (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .MemStall_i   (MemStall_i),
    .RegWrite_i   (RegWrite_i),
    .MemtoReg_i   (MemtoReg_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .ALUOp_i      (ALUOp_i),
    .ALUSrc_i     (ALUSrc_i),
    .RS1data_i    (RS1data_i),
    .RS2data_i    (RS2data_i),
    .Imm_i        (Imm_i),
    .ALUfunct_i   (ALUfunct_i),
    .RS1addr_i    (RS1addr_i),
    .RS2addr_i    (RS2addr_i),
    .RDaddr_i     (RDaddr_i),
    .WBRegWrite_i (WBRegWrite_i),
    .WBRDaddr_i   (WBRDaddr_i),
    .WBdata_i     (WBdata_i),
    .RegWrite_o   (RegWrite_o),
    .MemtoReg_o   (MemtoReg_o),
    .MemRead_o    (MemRead_o),
    .MemWrite_o   (MemWrite_o),
    .ALUResult_o  (ALUResult_o),
    .RS2data_o    (RS2data_o),
    .RDaddr_o     (RDaddr_o),
    .ExStall_o    (ExStall_o)
  );

  always #5 clk_i = ~clk_i;

  // ctl = {RegWrite, MemtoReg, MemRead, MemWrite}
  typedef struct packed {
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] rs2;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [9:0] fn, input logic src,
                       input logic [3:0] ctl, input logic [4:0] rs1a, input logic [4:0] rs2a,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm);
    ALUOp_i    = op;
    ALUfunct_i = fn;
    ALUSrc_i   = src;
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = ctl;
    RS1addr_i  = rs1a;
    RS2addr_i  = rs2a;
    RDaddr_i   = rd;
    RS1data_i  = d1;
    RS2data_i  = d2;
    Imm_i      = imm;
  endtask

  task automatic nop_inputs();
    drive(2'b00, 10'd0, 1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // One instruction for one cycle; expected EX/MEM content goes to the scoreboard
  task automatic issue(input logic [1:0] op, input logic [9:0] fn, input logic src,
                       input logic [3:0] ctl, input logic [4:0] rs1a, input logic [4:0] rs2a,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] exp_res,
                       input logic [31:0] exp_rs2);
    exp_t e;
    drive(op, fn, src, ctl, rs1a, rs2a, rd, d1, d2, imm);
    e.ctl = ctl;
    e.rd  = rd;
    e.res = exp_res;
    e.rs2 = exp_rs2;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop_cycles(input int n);
    nop_inputs();
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // mul x6,x7,x8 with 0xFFFFFFFF*3, held while ExStall_o is high
  task automatic run_mul(input int stall_at, input int exp_cyc);
    int   cnt;
    int   bad;
    exp_t e;
    cnt = 0;
    bad = 0;
    drive(2'b10, 10'b0000001_000, 1'b0, 4'b1000, 5'd7, 5'd8, 5'd6,
          32'hFFFF_FFFF, 32'd3, 32'd0);
    e.ctl = 4'b1000;
    e.rd  = 5'd6;
    e.res = 32'hFFFF_FFFD;
    e.rs2 = 32'd3;
    exp_q.push_back(e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!ExStall_o) break;
      cnt++;
      if (RegWrite_o || MemRead_o || MemWrite_o || MemtoReg_o) bad++;
      @(posedge clk_i);
      #1;
      MemStall_i = (stall_at > 0) && (cnt >= stall_at) && (cnt < stall_at + 4);
    end
    check("mul_stall_cycles", 96'(cnt), 96'(exp_cyc));
    check("mul_bubbles", 96'(bad), 96'd0);
    @(posedge clk_i);
    #1;
    nop_inputs();
  endtask

  // Scoreboard monitor: compare whenever EX/MEM holds a real instruction
  always @(negedge clk_i) begin
    exp_t e;
    exp_t a;
    if (rst_i === 1'b1 &&
        (RegWrite_o === 1'b1 || MemRead_o === 1'b1 || MemWrite_o === 1'b1)) begin
      a = {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, RDaddr_o, ALUResult_o, RS2data_o};
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL exmem_unexpected: got %0h expected none", a);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL exmem_out: got ctl=%b rd=%0d res=%h rs2=%h expected ctl=%b rd=%0d res=%h rs2=%h",
                   a.ctl, a.rd, a.res, a.rs2, e.ctl, e.rd, e.res, e.rs2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i        = 1'b0;
    MemStall_i   = 1'b0;
    WBRegWrite_i = 1'b0;
    WBRDaddr_i   = 5'd0;
    WBdata_i     = 32'd0;
    nop_inputs();

    // Reset with random inputs
    for (int c = 0; c < 2; c++) begin
      MemStall_i   = 1'($urandom);
      WBRegWrite_i = 1'($urandom);
      WBRDaddr_i   = 5'($urandom);
      WBdata_i     = $urandom;
      drive(2'($urandom), 10'($urandom), 1'($urandom), 4'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      @(posedge clk_i);
      #1;
      check("reset_outputs",
            96'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, RDaddr_o,
                 ALUResult_o, RS2data_o, ExStall_o}), 96'd0);
    end
    rst_i        = 1'b1;
    MemStall_i   = 1'b0;
    WBRegWrite_i = 1'b0;
    WBRDaddr_i   = 5'd0;
    WBdata_i     = 32'd0;
    nop_cycles(1);

    // Basic ALU, no hazards among these except the store data
    issue(2'b10, 10'b0000000_000, 0, 4'b1000, 5'd1,  5'd2,  5'd3,  32'd5,      32'd7,      32'd0, 32'd12,       32'd7);
    issue(2'b01, 10'b0000000_000, 0, 4'b1000, 5'd10, 5'd11, 5'd4,  32'd20,     32'd3,      32'd0, 32'd17,       32'd3);
    issue(2'b10, 10'b0000000_111, 0, 4'b1000, 5'd13, 5'd14, 5'd12, 32'hF0F0,   32'hFF00,   32'd0, 32'hF000,     32'hFF00);
    issue(2'b10, 10'b0000000_100, 0, 4'b1000, 5'd16, 5'd17, 5'd15, 32'hFF,     32'h0F,     32'd0, 32'hF0,       32'h0F);
    issue(2'b10, 10'b0000000_001, 0, 4'b1000, 5'd19, 5'd20, 5'd18, 32'd1,      32'h25,     32'd0, 32'd32,       32'h25);
    issue(2'b11, 10'b1111111_000, 1, 4'b1000, 5'd22, 5'd0,  5'd21, 32'd10,     32'd0,      32'hFFFF_FFFF, 32'd9, 32'd0);
    issue(2'b11, 10'b0100000_101, 1, 4'b1000, 5'd24, 5'd0,  5'd23, 32'h8000_0000, 32'd0,   32'h404, 32'hF800_0000, 32'd0);
    issue(2'b10, 10'b0000000_010, 0, 4'b1000, 5'd1,  5'd2,  5'd25, 32'd5,      32'd5,      32'd0, 32'd0,        32'd5);
    issue(2'b00, 10'b0000000_010, 1, 4'b1110, 5'd28, 5'd0,  5'd26, 32'h100,    32'd0,      32'd8, 32'h108,      32'd0);
    // store: data comes from the load still sitting in EX/MEM (x26)
    issue(2'b00, 10'b0000000_010, 1, 4'b0001, 5'd29, 5'd26, 5'd0,  32'h200,    32'hDEAD_BEEF, 32'd4, 32'h204,   32'h108);
    nop_cycles(2);

    // Forwarding priority: WB writes x1=4 throughout
    WBRegWrite_i = 1'b1;
    WBRDaddr_i   = 5'd1;
    WBdata_i     = 32'd4;
    issue(2'b11, 10'b0000000_000, 1, 4'b1000, 5'd0, 5'd0, 5'd1, 32'd0,   32'd0, 32'd9, 32'd9, 32'd0);
    issue(2'b01, 10'b0000000_000, 0, 4'b1000, 5'd1, 5'd0, 5'd5, 32'd111, 32'd0, 32'd0, 32'd9, 32'd0);
    issue(2'b11, 10'b0000000_000, 1, 4'b1000, 5'd0, 5'd0, 5'd0, 32'd0,   32'd0, 32'd9, 32'd9, 32'd0);
    issue(2'b01, 10'b0000000_000, 0, 4'b1000, 5'd1, 5'd0, 5'd5, 32'd111, 32'd0, 32'd0, 32'd4, 32'd0);
    WBRDaddr_i = 5'd0;
    issue(2'b01, 10'b0000000_000, 0, 4'b1000, 5'd1, 5'd0, 5'd6, 32'd30,  32'd0, 32'd0, 32'd30, 32'd0);
    issue(2'b01, 10'b0000000_000, 0, 4'b1000, 5'd0, 5'd0, 5'd7, 32'd20,  32'd3, 32'd0, 32'd17, 32'd3);
    WBRegWrite_i = 1'b0;
    WBdata_i     = 32'd0;
    nop_cycles(2);

    // MUL: plain, then with a 4-cycle D-cache stall in RUN
    run_mul(0, 33);
    nop_cycles(2);
    run_mul(10, 37);
    nop_cycles(2);

    // Reset in the middle of RUN
    drive(2'b10, 10'b0000001_000, 1'b0, 4'b1000, 5'd7, 5'd8, 5'd6, 32'hFFFF_FFFF, 32'd3, 32'd0);
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_mid_mul_stall", 96'(ExStall_o), 96'd0);
    @(posedge clk_i);
    #1;
    check("reset_mid_mul_outputs",
          96'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, RDaddr_o,
               ALUResult_o, RS2data_o, ExStall_o}), 96'd0);
    rst_i = 1'b1;
    nop_inputs();
    @(negedge clk_i);
    check("after_reset_idle", 96'(ExStall_o), 96'd0);
    @(posedge clk_i);
    #1;
    run_mul(0, 33);
    nop_cycles(3);

    check("scoreboard_drained", 96'(exp_q.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
